// File: rtl/mmu_client_engine.sv
// mmu_client_engine
//   Initiator-side traffic engine for the MMU user interface. A run issues
//   num_ops alloc requests and parks every granted page in a local handle
//   FIFO. Each parked handle is then returned through a free request. The
//   engine pops both response streams, keeps saturating statistics and
//   raises a sticky flag when a response id is out of sequence.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse, honoured only in IDLE or DONE
//   num_ops, page_count   run length and page count, latched at start
//   busy, done            RUN/DRAIN and DONE indications
//   alloc_req_*           alloc request strobe, id and page count
//   free_req_*            free request strobe, id, page index and page count
//   alloc_rsp_pop,
//   free_rsp_pop          response FIFO pop strobes
//   *_fifo_full,
//   *_fifo_not_empty      MMU FIFO flags
//   alloc_rsp_*,
//   free_rsp_*            response payloads, valid the cycle after a pop
//   *_cnt                 saturating statistics
//   last_fail_reason      reason of the latest failing response
//   id_err                sticky response-id sequence error
module mmu_client_engine #(
  parameter int ID_W         = 13,
  parameter int SIZE_W       = 4,
  parameter int PAGE_IDX_W   = 15,
  parameter int REASON_W     = 2,
  parameter int HANDLE_PTR   = 4,
  parameter int HANDLE_DEPTH = 16,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_ops,
  input  logic [SIZE_W-1:0]     page_count,
  output logic                  busy,
  output logic                  done,
  output logic                  alloc_req_submit,
  output logic [ID_W-1:0]       alloc_req_id,
  output logic [SIZE_W-1:0]     alloc_req_page_count,
  output logic                  free_req_submit,
  output logic [ID_W-1:0]       free_req_id,
  output logic [PAGE_IDX_W-1:0] free_req_page_idx,
  output logic [SIZE_W-1:0]     free_req_page_count,
  output logic                  alloc_rsp_pop,
  output logic                  free_rsp_pop,
  input  logic                  alloc_req_fifo_full,
  input  logic                  free_req_fifo_full,
  input  logic                  alloc_rsp_fifo_not_empty,
  input  logic                  free_rsp_fifo_not_empty,
  input  logic [ID_W-1:0]       alloc_rsp_id,
  input  logic [ID_W-1:0]       free_rsp_id,
  input  logic [PAGE_IDX_W-1:0] alloc_rsp_page_idx,
  input  logic                  alloc_rsp_fail,
  input  logic                  free_rsp_fail,
  input  logic [REASON_W-1:0]   alloc_rsp_fail_reason,
  input  logic [REASON_W-1:0]   free_rsp_fail_reason,
  output logic [CNT_W-1:0]      alloc_ok_cnt,
  output logic [CNT_W-1:0]      alloc_fail_cnt,
  output logic [CNT_W-1:0]      free_ok_cnt,
  output logic [CNT_W-1:0]      free_fail_cnt,
  output logic [REASON_W-1:0]   last_fail_reason,
  output logic                  id_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      CNT_MAX = {CNT_W{1'b1}};
  localparam logic [HANDLE_PTR-1:0] PTR_ONE = {{(HANDLE_PTR-1){1'b0}}, 1'b1};
  localparam logic [HANDLE_PTR:0]   HC_ONE  = {{HANDLE_PTR{1'b0}}, 1'b1};

  logic [1:0]            state_r;
  logic [CNT_W-1:0]      ops_r;
  logic [SIZE_W-1:0]     pc_r;
  logic [CNT_W-1:0]      alloc_seq_r;
  logic [CNT_W-1:0]      alloc_seen_r;
  logic [CNT_W-1:0]      free_seq_r;
  logic [CNT_W-1:0]      free_seen_r;
  logic                  alloc_cap_r;
  logic                  free_cap_r;
  logic [HANDLE_PTR-1:0] wr_ptr_r;
  logic [HANDLE_PTR-1:0] rd_ptr_r;
  logic [HANDLE_PTR:0]   hcnt_r;
  logic [PAGE_IDX_W-1:0] handle_mem_r [HANDLE_DEPTH];

  logic                  active_s;
  logic                  start_ok_s;
  logic [CNT_W-1:0]      outstanding_s;
  logic                  alloc_go_s;
  logic                  free_go_s;
  logic                  push_s;
  logic                  drained_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  assign busy                 = (state_r == S_RUN) || (state_r == S_DRAIN);
  assign done                 = (state_r == S_DONE);
  assign alloc_req_page_count = pc_r;
  assign free_req_page_count  = pc_r;

  // Issue/pop decisions from registered state and the sampled MMU flags.
  always_comb begin
    active_s      = busy;
    start_ok_s    = start && ((state_r == S_IDLE) || (state_r == S_DONE));
    // Requests in flight plus parked handles: bounding this by the FIFO
    // depth means every future grant always has a slot to land in.
    outstanding_s = alloc_seq_r - alloc_seen_r + CNT_W'(hcnt_r);
    alloc_go_s    = (state_r == S_RUN) && !alloc_req_fifo_full &&
                    (alloc_seq_r != ops_r) &&
                    (outstanding_s < CNT_W'(HANDLE_DEPTH));
    free_go_s     = active_s && (hcnt_r != '0) && !free_req_fifo_full;
    push_s        = alloc_cap_r && !alloc_rsp_fail;
    drained_s     = (alloc_seen_r == ops_r) && (hcnt_r == '0) &&
                    (free_seq_r == free_seen_r) &&
                    !(alloc_rsp_pop || alloc_cap_r || free_rsp_pop || free_cap_r);
  end

  // Handle FIFO storage; occupancy and pointers live in the control block.
  always_ff @(posedge clk) begin
    if (push_s) begin
      handle_mem_r[wr_ptr_r] <= alloc_rsp_page_idx;
    end else begin
      handle_mem_r[wr_ptr_r] <= handle_mem_r[wr_ptr_r];
    end
  end

  // Run control, request issue, response capture and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= S_IDLE;
      ops_r             <= '0;
      pc_r              <= '0;
      alloc_seq_r       <= '0;
      alloc_seen_r      <= '0;
      free_seq_r        <= '0;
      free_seen_r       <= '0;
      alloc_cap_r       <= 1'b0;
      free_cap_r        <= 1'b0;
      wr_ptr_r          <= '0;
      rd_ptr_r          <= '0;
      hcnt_r            <= '0;
      alloc_req_submit  <= 1'b0;
      alloc_req_id      <= '0;
      free_req_submit   <= 1'b0;
      free_req_id       <= '0;
      free_req_page_idx <= '0;
      alloc_rsp_pop     <= 1'b0;
      free_rsp_pop      <= 1'b0;
      alloc_ok_cnt      <= '0;
      alloc_fail_cnt    <= '0;
      free_ok_cnt       <= '0;
      free_fail_cnt     <= '0;
      last_fail_reason  <= '0;
      id_err            <= 1'b0;
    end else if (start_ok_s) begin
      state_r          <= S_RUN;
      ops_r            <= num_ops;
      pc_r             <= page_count;
      alloc_seq_r      <= '0;
      alloc_seen_r     <= '0;
      free_seq_r       <= '0;
      free_seen_r      <= '0;
      alloc_cap_r      <= 1'b0;
      free_cap_r       <= 1'b0;
      wr_ptr_r         <= '0;
      rd_ptr_r         <= '0;
      hcnt_r           <= '0;
      alloc_req_submit <= 1'b0;
      free_req_submit  <= 1'b0;
      alloc_rsp_pop    <= 1'b0;
      free_rsp_pop     <= 1'b0;
      alloc_ok_cnt     <= '0;
      alloc_fail_cnt   <= '0;
      free_ok_cnt      <= '0;
      free_fail_cnt    <= '0;
      id_err           <= 1'b0;
    end else begin
      alloc_req_submit <= alloc_go_s;
      if (alloc_go_s) begin
        alloc_req_id <= {1'b0, alloc_seq_r[ID_W-2:0]};
        alloc_seq_r  <= alloc_seq_r + CNT_ONE;
      end
      free_req_submit <= free_go_s;
      if (free_go_s) begin
        free_req_id       <= {1'b1, free_seq_r[ID_W-2:0]};
        free_req_page_idx <= handle_mem_r[rd_ptr_r];
        rd_ptr_r          <= rd_ptr_r + PTR_ONE;
        free_seq_r        <= free_seq_r + CNT_ONE;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      case ({push_s, free_go_s})
        2'b10:   hcnt_r <= hcnt_r + HC_ONE;
        2'b01:   hcnt_r <= hcnt_r - HC_ONE;
        default: hcnt_r <= hcnt_r;
      endcase

      // A pop is never issued back-to-back so each capture slot sees
      // exactly one response word.
      alloc_rsp_pop <= active_s && alloc_rsp_fifo_not_empty && !alloc_rsp_pop;
      free_rsp_pop  <= active_s && free_rsp_fifo_not_empty && !free_rsp_pop;
      alloc_cap_r   <= alloc_rsp_pop;
      free_cap_r    <= free_rsp_pop;

      if (alloc_cap_r) begin
        alloc_seen_r <= alloc_seen_r + CNT_ONE;
        if (alloc_rsp_id != {1'b0, alloc_seen_r[ID_W-2:0]}) begin
          id_err <= 1'b1;
        end
        if (alloc_rsp_fail) begin
          alloc_fail_cnt <= sat_inc(alloc_fail_cnt);
        end else begin
          alloc_ok_cnt <= sat_inc(alloc_ok_cnt);
        end
      end
      if (free_cap_r) begin
        free_seen_r <= free_seen_r + CNT_ONE;
        if (free_rsp_id != {1'b1, free_seen_r[ID_W-2:0]}) begin
          id_err <= 1'b1;
        end
        if (free_rsp_fail) begin
          free_fail_cnt <= sat_inc(free_fail_cnt);
        end else begin
          free_ok_cnt <= sat_inc(free_ok_cnt);
        end
      end
      // Free reason takes precedence when both streams fail together.
      if (free_cap_r && free_rsp_fail) begin
        last_fail_reason <= free_rsp_fail_reason;
      end else if (alloc_cap_r && alloc_rsp_fail) begin
        last_fail_reason <= alloc_rsp_fail_reason;
      end

      case (state_r)
        S_RUN: begin
          if (alloc_seq_r == ops_r) begin
            state_r <= drained_s ? S_DONE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drained_s) begin
            state_r <= S_DONE;
          end
        end
        default: state_r <= state_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_client_engine.sv
module tb_mmu_client_engine;
  localparam int ID_W = 13, SIZE_W = 4, PAGE_IDX_W = 15, REASON_W = 2, CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n, start;
  logic [CNT_W-1:0] num_ops;
  logic [SIZE_W-1:0] page_count;
  logic busy, done;
  logic alloc_req_submit, free_req_submit, alloc_rsp_pop, free_rsp_pop;
  logic [ID_W-1:0] alloc_req_id, free_req_id, alloc_rsp_id, free_rsp_id;
  logic [SIZE_W-1:0] alloc_req_page_count, free_req_page_count;
  logic [PAGE_IDX_W-1:0] free_req_page_idx, alloc_rsp_page_idx;
  logic alloc_req_fifo_full, free_req_fifo_full;
  logic alloc_rsp_fifo_not_empty, free_rsp_fifo_not_empty;
  logic alloc_rsp_fail, free_rsp_fail;
  logic [REASON_W-1:0] alloc_rsp_fail_reason, free_rsp_fail_reason, last_fail_reason;
  logic [CNT_W-1:0] alloc_ok_cnt, alloc_fail_cnt, free_ok_cnt, free_fail_cnt;
  logic id_err;

  always #5 clk = ~clk;

  mmu_client_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops), .page_count(page_count),
    .busy(busy), .done(done),
    .alloc_req_submit(alloc_req_submit), .alloc_req_id(alloc_req_id),
    .alloc_req_page_count(alloc_req_page_count),
    .free_req_submit(free_req_submit), .free_req_id(free_req_id),
    .free_req_page_idx(free_req_page_idx), .free_req_page_count(free_req_page_count),
    .alloc_rsp_pop(alloc_rsp_pop), .free_rsp_pop(free_rsp_pop),
    .alloc_req_fifo_full(alloc_req_fifo_full), .free_req_fifo_full(free_req_fifo_full),
    .alloc_rsp_fifo_not_empty(alloc_rsp_fifo_not_empty),
    .free_rsp_fifo_not_empty(free_rsp_fifo_not_empty),
    .alloc_rsp_id(alloc_rsp_id), .free_rsp_id(free_rsp_id),
    .alloc_rsp_page_idx(alloc_rsp_page_idx),
    .alloc_rsp_fail(alloc_rsp_fail), .free_rsp_fail(free_rsp_fail),
    .alloc_rsp_fail_reason(alloc_rsp_fail_reason), .free_rsp_fail_reason(free_rsp_fail_reason),
    .alloc_ok_cnt(alloc_ok_cnt), .alloc_fail_cnt(alloc_fail_cnt),
    .free_ok_cnt(free_ok_cnt), .free_fail_cnt(free_fail_cnt),
    .last_fail_reason(last_fail_reason), .id_err(id_err)
  );

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [PAGE_IDX_W-1:0] page;
    logic                  fail;
    logic [REASON_W-1:0]   reason;
  } rsp_t;

  rsp_t a_pend[$], a_rspq[$], f_pend[$], f_rspq[$];
  logic [PAGE_IDX_W-1:0] granted_q[$], fpages[$];

  int checks = 0;
  int failures = 0;

  // Reference model of one run
  int a_issued, f_issued, a_pops, f_pops, a_ok_m, a_fail_m, f_ok_m, f_fail_m;
  logic [REASON_W-1:0] lfr_m = '0;
  logic id_err_m = 1'b0;
  logic [SIZE_W-1:0] pc_m;

  // Responder knobs
  int fail_at = -1;
  logic [REASON_W-1:0] fail_reason = 2'b00;
  bit rand_fail = 0, page_mode = 1, swap_mode = 0, rand_full = 0;
  int a_rate = 100, f_rate = 100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // MMU responder: accepts requests, answers in order after a random delay
  always @(negedge clk) begin
    rsp_t r;
    if (!rst_n) begin
      a_pend.delete(); a_rspq.delete(); f_pend.delete(); f_rspq.delete();
      alloc_rsp_fifo_not_empty = 1'b0; free_rsp_fifo_not_empty = 1'b0;
      alloc_rsp_id = '0; alloc_rsp_page_idx = '0; alloc_rsp_fail = 1'b0; alloc_rsp_fail_reason = '0;
      free_rsp_id = '0; free_rsp_fail = 1'b0; free_rsp_fail_reason = '0;
    end else begin
      if (alloc_req_submit === 1'b1) begin
        check("alloc_id", 32'(alloc_req_id), 32'(a_issued % 4096));
        check("alloc_pc", 32'(alloc_req_page_count), 32'(pc_m));
        r.id = alloc_req_id;
        r.page = page_mode ? PAGE_IDX_W'(a_issued) : PAGE_IDX_W'($urandom);
        r.reason = REASON_W'($urandom);
        r.fail = 1'b0;
        if (a_issued == fail_at) begin
          r.fail = 1'b1; r.reason = fail_reason;
        end else if (rand_fail && $urandom_range(0, 7) == 0) begin
          r.fail = 1'b1;
        end
        a_pend.push_back(r);
        a_issued++;
        check("inflight_bound", 32'((a_issued - a_fail_m - f_issued) <= 16), 32'd1);
      end
      if (free_req_submit === 1'b1) begin
        check("free_id", 32'(free_req_id), 32'h1000 + 32'(f_issued % 4096));
        check("free_pc", 32'(free_req_page_count), 32'(pc_m));
        check("free_has_handle", 32'(granted_q.size() != 0), 32'd1);
        if (granted_q.size() != 0)
          check("free_page", 32'(free_req_page_idx), 32'(granted_q.pop_front()));
        fpages.push_back(free_req_page_idx);
        r.id = free_req_id; r.page = free_req_page_idx;
        r.fail = rand_fail && ($urandom_range(0, 7) == 0);
        r.reason = REASON_W'($urandom);
        f_pend.push_back(r);
        f_issued++;
      end
      if (alloc_rsp_pop === 1'b1) begin
        check("alloc_pop_nonempty", 32'(a_rspq.size() != 0), 32'd1);
        if (a_rspq.size() != 0) begin
          r = a_rspq.pop_front();
          alloc_rsp_id = r.id; alloc_rsp_page_idx = r.page;
          alloc_rsp_fail = r.fail; alloc_rsp_fail_reason = r.reason;
          if (r.id != ID_W'(a_pops % 4096)) id_err_m = 1'b1;
          a_pops++;
          if (r.fail) begin a_fail_m++; lfr_m = r.reason; end
          else begin a_ok_m++; granted_q.push_back(r.page); end
        end
      end
      if (free_rsp_pop === 1'b1) begin
        check("free_pop_nonempty", 32'(f_rspq.size() != 0), 32'd1);
        if (f_rspq.size() != 0) begin
          r = f_rspq.pop_front();
          free_rsp_id = r.id; free_rsp_fail = r.fail; free_rsp_fail_reason = r.reason;
          if (r.id != (ID_W'(f_pops % 4096) | 13'h1000)) id_err_m = 1'b1;
          f_pops++;
          if (r.fail) begin f_fail_m++; lfr_m = r.reason; end
          else f_ok_m++;
        end
      end
      if (swap_mode) begin
        if (a_pend.size() == 3) begin
          a_rspq.push_back(a_pend[0]); a_rspq.push_back(a_pend[2]); a_rspq.push_back(a_pend[1]);
          a_pend.delete();
          swap_mode = 0;
        end
      end else if (a_pend.size() != 0 && $urandom_range(1, 100) <= a_rate) begin
        a_rspq.push_back(a_pend.pop_front());
      end
      if (f_pend.size() != 0 && $urandom_range(1, 100) <= f_rate)
        f_rspq.push_back(f_pend.pop_front());
      alloc_rsp_fifo_not_empty = (a_rspq.size() != 0);
      free_rsp_fifo_not_empty  = (f_rspq.size() != 0);
    end
  end

  task automatic do_start(input int n, input logic [SIZE_W-1:0] pc);
    a_issued = 0; f_issued = 0; a_pops = 0; f_pops = 0;
    a_ok_m = 0; a_fail_m = 0; f_ok_m = 0; f_fail_m = 0;
    id_err_m = 1'b0; pc_m = pc;
    granted_q.delete(); fpages.delete();
    num_ops = CNT_W'(n); page_count = pc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      if (rand_full) begin
        alloc_req_fifo_full = ($urandom_range(0, 3) == 0);
        free_req_fifo_full  = ($urandom_range(0, 3) == 0);
      end
      k++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    alloc_req_fifo_full = 1'b0; free_req_fifo_full = 1'b0;
  endtask

  task automatic final_check(input string tag, input int n);
    repeat (3) @(negedge clk);
    check({tag, "_allocs"}, 32'(a_issued), 32'(n));
    check({tag, "_frees"}, 32'(f_issued), 32'(a_ok_m));
    check({tag, "_aok"}, 32'(alloc_ok_cnt), 32'(a_ok_m));
    check({tag, "_afail"}, 32'(alloc_fail_cnt), 32'(a_fail_m));
    check({tag, "_fok"}, 32'(free_ok_cnt), 32'(f_ok_m));
    check({tag, "_ffail"}, 32'(free_fail_cnt), 32'(f_fail_m));
    check({tag, "_lfr"}, 32'(last_fail_reason), 32'(lfr_m));
    check({tag, "_iderr"}, 32'(id_err), 32'(id_err_m));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_hold"}, 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; num_ops = '0; page_count = '0;
    alloc_req_fifo_full = 1'b0; free_req_fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_asub", 32'(alloc_req_submit), 32'd0);
    check("rst_aok", 32'(alloc_ok_cnt), 32'd0);
    check("rst_lfr", 32'(last_fail_reason), 32'd0);
    check("rst_iderr", 32'(id_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: four ops, pages 0..3
    page_mode = 1;
    do_start(4, 4'd1);
    wait_done("t1", 500);
    final_check("t1", 4);
    check("t1_nfree", 32'(fpages.size()), 32'd4);
    for (int i = 0; i < 4 && i < fpages.size(); i++)
      check("t1_free_page_order", 32'(fpages[i]), 32'(i));

    // Free path blocked: allocs stall at 16 outstanding handles
    free_req_fifo_full = 1'b1;
    do_start(40, 4'd2);
    repeat (150) @(negedge clk);
    check("t2_stall_allocs", 32'(a_issued), 32'd16);
    check("t2_stall_aok", 32'(alloc_ok_cnt), 32'd16);
    check("t2_stall_busy", 32'(busy), 32'd1);
    free_req_fifo_full = 1'b0;
    wait_done("t2", 2000);
    final_check("t2", 40);

    // alloc_req_fifo_full window of 10 cycles
    do_start(30, 4'd3);
    repeat (5) @(negedge clk);
    alloc_req_fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_no_issue_when_full", 32'(alloc_req_submit), 32'd0);
    end
    alloc_req_fifo_full = 1'b0;
    @(negedge clk);
    check("t3_resume", 32'(alloc_req_submit), 32'd1);
    wait_done("t3", 2000);
    final_check("t3", 30);

    // Alloc #2 fails with reason 01
    fail_at = 2; fail_reason = 2'b01;
    do_start(4, 4'd1);
    wait_done("t4", 500);
    final_check("t4", 4);
    check("t4_afail", 32'(alloc_fail_cnt), 32'd1);
    check("t4_lfr", 32'(last_fail_reason), 32'd1);
    check("t4_nfree", 32'(f_issued), 32'd3);
    fail_at = -1;

    // Out-of-order alloc ids 0,2,1
    swap_mode = 1;
    do_start(3, 4'd1);
    wait_done("t5", 500);
    final_check("t5", 3);
    check("t5_iderr", 32'(id_err), 32'd1);
    repeat (5) @(negedge clk);
    check("t5_iderr_sticky", 32'(id_err), 32'd1);
    do_start(2, 4'd1);
    check("t5_iderr_cleared", 32'(id_err), 32'd0);
    wait_done("t5b", 500);
    final_check("t5b", 2);

    // Randomized runs
    page_mode = 0; rand_fail = 1; rand_full = 1; a_rate = 50; f_rate = 50;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(20, 60);
      do_start(n, SIZE_W'($urandom));
      wait_done("rand", 5000);
      final_check("rand", n);
    end
    rand_full = 0; rand_fail = 0; a_rate = 100; f_rate = 100;

    // Reset mid-run, then an empty run
    do_start(20, 4'd2);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstm_busy", 32'(busy), 32'd0);
    check("rstm_asub", 32'(alloc_req_submit), 32'd0);
    check("rstm_fsub", 32'(free_req_submit), 32'd0);
    check("rstm_aok", 32'(alloc_ok_cnt), 32'd0);
    check("rstm_fok", 32'(free_ok_cnt), 32'd0);
    lfr_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_start(0, 4'd0);
    check("t6_done_not_yet", 32'(done), 32'd0);
    @(negedge clk);
    check("t6_done_one_cycle", 32'(done), 32'd1);
    final_check("t6", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
